// File: rtl/fp_pkg.sv
// Shared IEEE-754 single-precision constants and types for the pack/unpack datapaths.
package fp_pkg;

    localparam int FP_BIAS       = 127;
    localparam int FP_EXP_W      = 8;
    localparam int FP_FRAC_W     = 23;
    localparam int FP_EXP_INF    = 128;
    localparam int FP_EXP_DENORM = 1 - FP_BIAS;

    localparam int UNP_EXP_W   = 10;
    localparam int UNP_MANT_W  = FP_FRAC_W + 1;
    localparam int UNP_SHIFT_W = 5;

    localparam logic [FP_EXP_W-1:0] FP_EXP_MAX = '1;

    typedef struct packed {
        logic zero;
        logic denorm;
        logic inf;
        logic nan;
        logic snan;
    } fp_class_t;

    typedef enum logic [1:0] {
        UNP_IDLE,
        UNP_CLASSIFY,
        UNP_NORM,
        UNP_DONE
    } unpack_state_e;

endpackage

// File: rtl/fp_unpack_if.sv
// Request/result bundle between an operand source and the fp_unpack block.
interface fp_unpack_if;
    import fp_pkg::*;

    logic                   start;
    logic [31:0]            operand;
    logic                   busy;
    logic                   done;
    logic                   s_out;
    logic [UNP_EXP_W-1:0]   e_out;
    logic [UNP_MANT_W-1:0]  mant_out;
    logic [UNP_SHIFT_W-1:0] norm_shift;
    logic                   is_zero;
    logic                   is_denorm;
    logic                   is_inf;
    logic                   is_nan;
    logic                   is_snan;

    modport master (
        output start, operand,
        input  busy, done, s_out, e_out, mant_out, norm_shift,
        input  is_zero, is_denorm, is_inf, is_nan, is_snan
    );

    modport slave (
        input  start, operand,
        output busy, done, s_out, e_out, mant_out, norm_shift,
        output is_zero, is_denorm, is_inf, is_nan, is_snan
    );

endinterface

// File: rtl/fp_classify.sv
// Combinational IEEE single classifier: class flags plus initial unbiased exponent and mantissa.
module fp_classify
    import fp_pkg::*;
(
    input  logic [31:0]           word_i,
    output logic                  sign_o,
    output fp_class_t             cls_o,
    output logic [UNP_EXP_W-1:0]  exp_o,
    output logic [UNP_MANT_W-1:0] mant_o
);

    logic [FP_EXP_W-1:0]  exp_field;
    logic [FP_FRAC_W-1:0] frac_field;

    assign sign_o     = word_i[31];
    assign exp_field  = word_i[FP_FRAC_W +: FP_EXP_W];
    assign frac_field = word_i[FP_FRAC_W-1:0];

    always_comb begin
        cls_o  = '0;
        exp_o  = '0;
        mant_o = '0;
        if (exp_field == '0) begin
            if (frac_field == '0) begin
                cls_o.zero = 1'b1;
            end else begin
                // Subnormal starts at the minimum normal exponent; the caller normalizes.
                cls_o.denorm = 1'b1;
                exp_o        = UNP_EXP_W'(FP_EXP_DENORM);
                mant_o       = {1'b0, frac_field};
            end
        end else if (exp_field == FP_EXP_MAX) begin
            exp_o = UNP_EXP_W'(FP_EXP_INF);
            if (frac_field == '0) begin
                cls_o.inf = 1'b1;
                mant_o    = {1'b1, {FP_FRAC_W{1'b0}}};
            end else begin
                cls_o.nan  = 1'b1;
                cls_o.snan = ~frac_field[FP_FRAC_W-1];
                mant_o     = {1'b1, frac_field};
            end
        end else begin
            exp_o  = UNP_EXP_W'(int'(exp_field) - FP_BIAS);
            mant_o = {1'b1, frac_field};
        end
    end

endmodule

// File: rtl/fp_unpack.sv
// Multi-cycle IEEE single unpacker; subnormals are normalized one bit per cycle.
// state    | meaning
// IDLE     | waiting for start
// CLASSIFY | decode captured operand, load result registers
// NORM     | subnormal: shift mantissa left, decrement exponent
// DONE     | result valid for one cycle; start here chains the next operand
module fp_unpack
    import fp_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    fp_unpack_if.slave bus
);

    unpack_state_e          state_q;
    logic [31:0]            operand_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   sign_q;
    logic [UNP_EXP_W-1:0]   exp_q;
    logic [UNP_MANT_W-1:0]  mant_q;
    logic [UNP_SHIFT_W-1:0] shift_q;
    fp_class_t              cls_q;

    logic                  cls_sign;
    fp_class_t             cls;
    logic [UNP_EXP_W-1:0]  cls_exp;
    logic [UNP_MANT_W-1:0] cls_mant;

    fp_classify u_classify (
        .word_i (operand_q),
        .sign_o (cls_sign),
        .cls_o  (cls),
        .exp_o  (cls_exp),
        .mant_o (cls_mant)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= UNP_IDLE;
            operand_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            sign_q    <= 1'b0;
            exp_q     <= '0;
            mant_q    <= '0;
            shift_q   <= '0;
            cls_q     <= '0;
        end else begin
            case (state_q)
                UNP_IDLE, UNP_DONE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        operand_q <= bus.operand;
                        cls_q     <= '0;
                        shift_q   <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= UNP_CLASSIFY;
                    end else begin
                        state_q <= UNP_IDLE;
                    end
                end
                UNP_CLASSIFY: begin
                    sign_q <= cls_sign;
                    exp_q  <= cls_exp;
                    mant_q <= cls_mant;
                    cls_q  <= cls;
                    if (cls.denorm) begin
                        state_q <= UNP_NORM;
                    end else begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= UNP_DONE;
                    end
                end
                UNP_NORM: begin
                    mant_q  <= {mant_q[UNP_MANT_W-2:0], 1'b0};
                    exp_q   <= exp_q - UNP_EXP_W'(1);
                    shift_q <= shift_q + UNP_SHIFT_W'(1);
                    // Bit below the leading position set means this shift lands the leading one.
                    if (mant_q[UNP_MANT_W-2]) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= UNP_DONE;
                    end
                end
                default: state_q <= UNP_IDLE;
            endcase
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.s_out      = sign_q;
    assign bus.e_out      = exp_q;
    assign bus.mant_out   = mant_q;
    assign bus.norm_shift = shift_q;
    assign bus.is_zero    = cls_q.zero;
    assign bus.is_denorm  = cls_q.denorm;
    assign bus.is_inf     = cls_q.inf;
    assign bus.is_nan     = cls_q.nan;
    assign bus.is_snan    = cls_q.snan;

endmodule

// File: tb/tb_fp_unpack.sv
// Self-checking bench for fp_unpack: directed cases plus random operands against a value-level model.
module tb_fp_unpack;

    logic clk;
    logic rst_n;
    int   n_assert;
    int   n_fail;

    fp_unpack_if bus ();

    fp_unpack u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [9:0]  e;
        logic [23:0] m;
        logic [4:0]  sh;
        logic        z;
        logic        d;
        logic        inf;
        logic        nan;
        logic        snan;
        int          lat;
    } exp_t;

    // Reference derived from the numeric value: subnormal f*2^-149 normalized to 1.xxx * 2^e.
    function automatic exp_t model(input logic [31:0] w);
        exp_t r;
        int   ex;
        int   f;
        int   p;
        ex = int'(w[30:23]);
        f  = int'(w[22:0]);
        r.e = '0; r.m = '0; r.sh = '0;
        r.z = 1'b0; r.d = 1'b0; r.inf = 1'b0; r.nan = 1'b0; r.snan = 1'b0;
        r.lat = 2;
        if (ex == 0 && f == 0) begin
            r.z = 1'b1;
        end else if (ex == 0) begin
            p     = $clog2(f + 1) - 1;
            r.d   = 1'b1;
            r.sh  = 5'(23 - p);
            r.e   = 10'(p - 149);
            r.m   = 24'(f << (23 - p));
            r.lat = 2 + 23 - p;
        end else if (ex == 255) begin
            r.e = 10'(128);
            if (f == 0) begin
                r.inf = 1'b1;
                r.m   = 24'h800000;
            end else begin
                r.nan  = 1'b1;
                r.snan = (f < 32'h400000);
                r.m    = 24'(f + 32'h800000);
            end
        end else begin
            r.e = 10'(ex - 127);
            r.m = 24'(f + 32'h800000);
        end
        return r;
    endfunction

    function automatic logic [31:0] gen_word();
        logic [31:0] f;
        logic        s;
        s = 1'($urandom_range(0, 1));
        f = $urandom & 32'h7FFFFF;
        case ($urandom_range(0, 4))
            0: return {s, 31'h0};
            1: begin
                f = $urandom >> $urandom_range(9, 31);
                if (f == 0) f = 32'h1;
                return {s, 8'h00, f[22:0]};
            end
            2: return {s, 8'hFF, 23'h0};
            3: begin
                if (f == 0) f = 32'h1;
                return {s, 8'hFF, f[22:0]};
            end
            default: return {s, 8'($urandom_range(1, 254)), f[22:0]};
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic chk_result(input logic [31:0] w, input exp_t x);
        string t;
        t = $sformatf("w=%08h", w);
        chk({"sign ", t}, 64'(bus.s_out), 64'(w[31]));
        chk({"e_out ", t}, 64'(bus.e_out), 64'(x.e));
        chk({"mant ", t}, 64'(bus.mant_out), 64'(x.m));
        chk({"shift ", t}, 64'(bus.norm_shift), 64'(x.sh));
        chk({"flags ", t},
            64'({bus.is_zero, bus.is_denorm, bus.is_inf, bus.is_nan, bus.is_snan}),
            64'({x.z, x.d, x.inf, x.nan, x.snan}));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " ctl"}, 64'({bus.busy, bus.done, bus.s_out, bus.norm_shift}), 64'(0));
        chk({tag, " data"}, 64'({bus.e_out, bus.mant_out}), 64'(0));
        chk({tag, " flags"},
            64'({bus.is_zero, bus.is_denorm, bus.is_inf, bus.is_nan, bus.is_snan}), 64'(0));
    endtask

    task automatic issue(input logic [31:0] w);
        @(negedge clk);
        bus.start   = 1'b1;
        bus.operand = w;
    endtask

    // Expects start/operand already presented for the coming edge (edge 0); returns at the done cycle.
    task automatic complete(input logic [31:0] w, input bit chain, input logic [31:0] nw);
        exp_t x;
        x = model(w);
        @(posedge clk);
        for (int cyc = 1; cyc <= x.lat; cyc++) begin
            @(negedge clk);
            chk($sformatf("busy c%0d w=%08h", cyc, w), 64'(bus.busy), 64'(cyc < x.lat));
            chk($sformatf("done c%0d w=%08h", cyc, w), 64'(bus.done), 64'(cyc == x.lat));
            if (cyc < x.lat) begin
                bus.start   = 1'($urandom_range(0, 1));
                bus.operand = $urandom;
            end else begin
                chk_result(w, x);
                bus.start   = chain;
                bus.operand = nw;
            end
        end
    endtask

    task automatic idle_check(input logic [31:0] w, input int n);
        exp_t x;
        x = model(w);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk($sformatf("idle ctl w=%08h", w), 64'({bus.busy, bus.done}), 64'(0));
            chk($sformatf("idle hold w=%08h", w), 64'({bus.e_out, bus.mant_out}), 64'({x.e, x.m}));
        end
    endtask

    initial begin
        logic [31:0] w;
        logic [31:0] nw;
        bit          ch;
        n_assert    = 0;
        n_fail      = 0;
        rst_n       = 1'b0;
        bus.start   = 1'b0;
        bus.operand = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;

        issue(32'h3F800000);
        complete(32'h3F800000, 1'b0, 32'h0);
        chk("one mant", 64'(bus.mant_out), 64'h800000);
        idle_check(32'h3F800000, 2);

        issue(32'h00000001);
        complete(32'h00000001, 1'b0, 32'h0);
        chk("min denorm e", 64'(bus.e_out), 64'h36B);
        idle_check(32'h00000001, 1);

        issue(32'h80000000);
        complete(32'h80000000, 1'b1, 32'h7F800000);
        complete(32'h7F800000, 1'b0, 32'h0);
        chk("inf e", 64'(bus.e_out), 64'h080);

        issue(32'h7FA00000);
        complete(32'h7FA00000, 1'b1, 32'h7FC00000);
        complete(32'h7FC00000, 1'b0, 32'h0);
        chk("qnan mant", 64'(bus.mant_out), 64'hC00000);

        // Reset in cycle 10 of a long subnormal normalization.
        issue(32'h00000001);
        @(posedge clk);
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(negedge clk);
            bus.start = 1'b0;
            chk($sformatf("rst busy c%0d", cyc), 64'(bus.busy), 64'(1));
            if (cyc == 10) rst_n = 1'b0;
        end
        @(negedge clk);
        chk_all_zero("mid reset");
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post reset quiet", 64'({bus.busy, bus.done}), 64'(0));
        end
        issue(32'h40000000);
        complete(32'h40000000, 1'b0, 32'h0);
        chk("two e", 64'(bus.e_out), 64'(1));

        issue(32'h40000000);
        complete(32'h40000000, 1'b1, 32'h00400000);
        complete(32'h00400000, 1'b0, 32'h0);
        chk("chain denorm e", 64'(bus.e_out), 64'h381);
        idle_check(32'h00400000, 1);

        w = gen_word();
        issue(w);
        for (int i = 0; i < 60; i++) begin
            nw = gen_word();
            ch = bit'($urandom_range(0, 1));
            complete(w, ch, nw);
            if (!ch) begin
                idle_check(w, 1);
                issue(nw);
            end
            w = nw;
        end
        complete(w, 1'b0, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/fp_unpack.md
# fp_unpack

Multi-cycle IEEE-754 single-precision unpacker, the inverse of the FPU packing step. It accepts a packed 32-bit word on a start/done handshake and classifies it. Subnormal operands are pre-normalized by shifting one bit per cycle. It returns sign, unbiased signed exponent, 24-bit mantissa with explicit leading one, and class flags. It sits in front of the add/sub and multiply datapaths so they receive normalized operands.

## Interface
Parameters: none. The bias of 127 and the field widths are fixed constants from the shared package.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low; sampled on the rising edge of `clk`.
- `start`  in  1  request. Sampled only in IDLE or DONE.
- `operand`  in  32  packed IEEE single. Captured on the edge where `start` is accepted.
- `busy`  out  1  high in CLASSIFY and NORM.
- `done`  out  1  high for exactly the one cycle spent in DONE.
- `s_out`  out  1  sign.
- `e_out`  out  10  unbiased exponent, two's complement.
- `mant_out`  out  24  mantissa; bit 23 is the explicit leading bit.
- `norm_shift`  out  5  number of left shifts applied, 0..23.
- `is_zero`, `is_denorm`, `is_inf`, `is_nan`, `is_snan`  out  1 each  class flags, one-hot except that `is_snan` implies `is_nan`.

## Operation
- States: IDLE, CLASSIFY, NORM, DONE.
- IDLE: when `start` is high, register `operand` and go to CLASSIFY. Otherwise stay.
- CLASSIFY: decode with e = operand[30:23], f = operand[22:0].
  - e=0, f=0: zero. e_out=0, mant_out=0. Go to DONE.
  - e=0, f≠0: subnormal. mant={1'b0,f}, exp=-126, is_denorm=1. Go to NORM.
  - e=255, f=0: inf. e_out=+128, mant_out=0x800000. Go to DONE.
  - e=255, f≠0: NaN. e_out=+128, mant_out={1'b1,f}, is_snan=~f[22]. Go to DONE.
  - otherwise: normal. e_out=e-127, mant_out={1'b1,f}. Go to DONE.
  - `s_out` is operand[31] in every case, including zero and NaN.
- NORM, once per cycle:
  - mant <<= 1, exp -= 1, norm_shift += 1.
  - If the pre-shift mant[22] was 1, go to DONE; otherwise stay in NORM.
  - The number of NORM cycles equals the leading-zero count of {1'b0,f}, which ranges 1..23.
- DONE: assert `done`.
  - If `start` is high, capture the new `operand` and go to CLASSIFY (back-to-back).
  - Otherwise go to IDLE.
- Arithmetic: compute the exponent in 10-bit signed. Range is -149..+128, so it never overflows.
- Result outputs (`s_out`, `e_out`, `mant_out`, `norm_shift`, flags) hold their last value from DONE until the next CLASSIFY overwrites them. Clear the flags and norm_shift on every accept.

## Timing
- Reset (`rst_n`=0 at an edge): state goes to IDLE, and every output is 0 (`busy`, `done`, `s_out`, `e_out`, `mant_out`, `norm_shift`, all flags). Reset asserted mid-NORM aborts the operation; no `done` is issued.
- Latency is counted from the accepting edge (edge 0):
  - `done` is high in cycle 2 for zero, normal, inf and NaN.
  - `done` is high in cycle 2+norm_shift for subnormals, so the worst case is cycle 25.
- `start` during CLASSIFY or NORM is ignored; the operand is not re-captured.
- Throughput is one result per 2 cycles for non-subnormals when `start` is held high.
- `done` and `busy` are never high in the same cycle.

## Structure
- Shared package `fp_pkg`:
  - FP_BIAS=127, FP_EXP_W=8, FP_FRAC_W=23, FP_EXP_INF=+128.
  - State enum for this block.
  - Class struct/bit positions, shared with the packer side.
- One combinational sub-module, `fp_classify`: takes the 32-bit word and outputs the class flags, initial exponent and mantissa. Reuse it wherever a class check is needed.
- Keep the FSM, shifter and exponent counter in `fp_unpack`.

## Test plan
- 0x3F800000 → `done` in cycle 2: s=0, e_out=0, mant_out=0x800000, norm_shift=0, no flags.
- 0x00000001 → `done` in cycle 25: e_out=10'h36B (-149), mant_out=0x800000, norm_shift=23, is_denorm=1, busy high in cycles 1..24.
- 0x80000000 → `done` in cycle 2: is_zero=1, s_out=1, e_out=0, mant_out=0. Then 0x7F800000 → is_inf=1, e_out=10'h080.
- 0x7FA00000 → is_nan=1, is_snan=1. Then 0x7FC00000 → is_nan=1, is_snan=0, mant_out=0xC00000.
- Start 0x00000001, then pull `rst_n` low in cycle 10 → all outputs 0 next edge, no `done`. Then 0x40000000 → e_out=1, done in cycle 2.
- `start` held high with 0x40000000, then 0x00400000 presented during DONE → second word accepted. Its `done` comes 3 cycles later: e_out=10'h381 (-127), mant_out=0x800000, norm_shift=1. Pulsing `start` during NORM has no effect.
